// File: rtl/ifmap_feeder_pkg.sv
// Shared tag encodings, FSM state type and tag helper for the IFMAP stream feeder.
package ifmap_feeder_pkg;

  localparam logic [1:0] TAG_START  = 2'b10;
  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_END    = 2'b01;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } feeder_state_t;

  function automatic logic [1:0] make_tag(input logic first, input logic last);
    logic [1:0] tag;
    case ({first, last})
      2'b10:   tag = TAG_START;
      2'b01:   tag = TAG_END;
      2'b11:   tag = TAG_SINGLE;
      default: tag = TAG_MID;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/row_col_counter.sv
// Column/row walker over the feature map: position flags and the flat
// scratch address of the element that follows the current one.
module row_col_counter #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [LEN_WIDTH-1:0]  num_rows,
  output logic                  first_col,
  output logic                  last_col,
  output logic                  last_elem,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [LEN_WIDTH-1:0]  col, row, col_nx, row_nx;
  logic [ADDR_WIDTH-1:0] row_off, row_off_nx;

  assign first_col = (col == '0);
  assign last_col  = (col == row_len - 1'b1);
  assign last_elem = last_col && (row == num_rows - 1'b1);

  // row_off accumulates row*row_len so the flat address needs no multiplier
  always_comb begin
    col_nx     = col;
    row_nx     = row;
    row_off_nx = row_off;
    if (last_col) begin
      col_nx     = '0;
      row_nx     = row + 1'b1;
      row_off_nx = row_off + ADDR_WIDTH'(row_len);
    end else begin
      col_nx = col + 1'b1;
    end
    next_addr = base_addr + row_off_nx + ADDR_WIDTH'(col_nx);
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      col     <= '0;
      row     <= '0;
      row_off <= '0;
    end else if (advance) begin
      col     <= col_nx;
      row     <= row_nx;
      row_off <= row_off_nx;
    end
  end

endmodule

// File: rtl/ifmap_stream_feeder.sv
// Reads a feature map from scratch memory and streams it to the PE IFMAP
// buffer as {row_start,row_end,data} words, honouring ifmap_full backpressure.
module ifmap_stream_feeder
  import ifmap_feeder_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int LEN_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [LEN_WIDTH-1:0]     row_len,
  input  logic [LEN_WIDTH-1:0]     num_rows,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rdata,
  input  logic                     ifmap_full,
  output logic [ELEMENT_WIDTH+1:0] IFMAP,
  output logic                     write_en_IFMAP,
  output logic                     busy,
  output logic                     done
);

  feeder_state_t state;

  logic [ADDR_WIDTH-1:0]    base_q;
  logic [LEN_WIDTH-1:0]     len_q, rows_q;
  logic [ELEMENT_WIDTH-1:0] data_q, word;
  logic                     captured;
  logic                     first_col, last_col, last_elem;
  logic [ADDR_WIDTH-1:0]    next_addr;
  logic                     accept, advance;

  assign accept  = (state == IDLE) && start;
  assign advance = (state == SEND) && !ifmap_full;

  // read data is only valid in the first SEND cycle; a stall replays the captured copy
  assign word = captured ? data_q : mem_rdata;

  row_col_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .advance   (advance),
    .base_addr (base_q),
    .row_len   (len_q),
    .num_rows  (rows_q),
    .first_col (first_col),
    .last_col  (last_col),
    .last_elem (last_elem),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      base_q         <= '0;
      len_q          <= '0;
      rows_q         <= '0;
      data_q         <= '0;
      captured       <= 1'b0;
      mem_rd_en      <= 1'b0;
      mem_addr       <= '0;
      IFMAP          <= '0;
      write_en_IFMAP <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      mem_rd_en      <= 1'b0;
      write_en_IFMAP <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= row_len;
            rows_q <= num_rows;
            busy   <= 1'b1;
            if (row_len == '0 || num_rows == '0) begin
              state <= FIN;
            end else begin
              state     <= READ;
              mem_rd_en <= 1'b1;
              mem_addr  <= base_addr;
            end
          end
        end
        READ: begin
          state    <= SEND;
          captured <= 1'b0;
        end
        SEND: begin
          if (!captured) begin
            data_q   <= mem_rdata;
            captured <= 1'b1;
          end
          if (!ifmap_full) begin
            write_en_IFMAP <= 1'b1;
            IFMAP          <= {make_tag(first_col, last_col), word};
            if (last_elem) begin
              state <= FIN;
            end else begin
              state     <= READ;
              mem_rd_en <= 1'b1;
              mem_addr  <= next_addr;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_stream_feeder.sv
// Randomized self-checking bench: expected word/address streams are built
// from the row/column rules and compared against the DUT outputs.
module tb_ifmap_stream_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [4:0] row_len = '0;
  logic [4:0] num_rows = '0;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       ifmap_full = 1'b0;
  logic [9:0] IFMAP;
  logic       write_en_IFMAP;
  logic       busy;
  logic       done;

  ifmap_stream_feeder #(
    .ELEMENT_WIDTH (8),
    .ADDR_WIDTH    (8),
    .LEN_WIDTH     (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .row_len        (row_len),
    .num_rows       (num_rows),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .ifmap_full     (ifmap_full),
    .IFMAP          (IFMAP),
    .write_en_IFMAP (write_en_IFMAP),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [9:0] word_q[$];
  logic [7:0] addr_q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  int wr_cnt = 0, done_cnt = 0;
  logic [9:0] last_word = '0, first_word = '0;
  logic busy_at_done = 1'b0;
  bit mon_en = 1'b0, full_rnd = 1'b0, full_s = 1'b0;
  int full_hold = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // synchronous scratch memory: data one cycle after the read strobe
  always @(posedge clk) begin
    cyc++;
    full_s = ifmap_full;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (full_hold > 0) begin
      ifmap_full = 1'b1;
      full_hold--;
    end else begin
      ifmap_full = full_rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd_en) begin
        if (addr_q.size() == 0) check("extra_read", 32'(mem_addr), 32'hFFFF);
        else check("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (write_en_IFMAP) begin
        check("write_while_full", 32'(full_s), 0);
        if (word_q.size() == 0) check("extra_write", 32'(IFMAP), 32'hFFFF);
        else check("word", 32'(IFMAP), 32'(word_q.pop_front()));
        if (wr_cnt == 0) begin
          first_wr_cyc = cyc;
          first_word   = IFMAP;
        end
        wr_cnt++;
        last_wr_cyc = cyc;
        last_word   = IFMAP;
      end else begin
        check("ifmap_hold", 32'(IFMAP), 32'(last_word));
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic build_model(input logic [7:0] b, input int l, input int n);
    word_q.delete();
    addr_q.delete();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < l; c++) begin
        logic [7:0] a;
        a = 8'((int'(b) + r * l + c) % 256);
        addr_q.push_back(a);
        word_q.push_back({(c == 0), (c == l - 1), mem[a]});
      end
    wr_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [7:0] b, input int l, input int n);
    base_addr = b;
    row_len   = 5'(l);
    num_rows  = 5'(n);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic run(input logic [7:0] b, input int l, input int n,
                     input bit rnd_full, input bit extra_start);
    build_model(b, l, n);
    full_rnd = rnd_full;
    @(negedge clk); #1;
    pulse_start(b, l, n);
    start_cyc = cyc;
    check("busy_after_start", 32'(busy), 1);
    if (extra_start) begin
      @(negedge clk); #1;
      pulse_start(8'h40, 2, 2);
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    full_rnd = 1'b0;
    check("done_seen", 32'(done_cnt), 1);
    check("write_count", 32'(wr_cnt), 32'(l * n));
    check("words_left", 32'(word_q.size()), 0);
    check("reads_left", 32'(addr_q.size()), 0);
    check("busy_at_done", 32'(busy_at_done), 0);
    if (l * n > 0) begin
      check("done_after_last", 32'(done_cyc - last_wr_cyc), 1);
      if (!rnd_full) check("first_wr_latency", 32'(first_wr_cyc - start_cyc), 2);
    end else begin
      check("empty_done_latency", 32'(done_cyc - start_cyc), 1);
    end
    repeat (3) @(negedge clk);
    #1;
    check("single_done", 32'(done_cnt), 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_we", 32'(write_en_IFMAP), 0);
    check("rst_ifmap", 32'(IFMAP), 0);
    check("rst_busy", 32'({busy, done, mem_rd_en}), 0);
    rst = 1'b1;
    mon_en = 1'b1;

    // directed row with a start pulse arriving while busy
    mem[0] = 8'hFF; mem[1] = 8'h3F; mem[2] = 8'h3F; mem[3] = 8'h3F; mem[4] = 8'h7E;
    run(8'd0, 5, 1, 1'b0, 1'b1);
    check("t1_first_word", 32'(first_word), 32'h2FF);
    check("t1_last_word", 32'(last_word), 32'h17E);

    run(8'd20, 3, 2, 1'b0, 1'b0);
    run(8'd90, 1, 3, 1'b0, 1'b0);
    check("single_tag", 32'(last_word[9:8]), 32'h3);
    run(8'd250, 4, 2, 1'b0, 1'b0);
    run(8'd7, 0, 3, 1'b0, 1'b0);
    run(8'd7, 4, 0, 1'b0, 1'b0);

    // directed 4-cycle stall in the middle of a row
    fork
      run(8'd100, 6, 1, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 100 && wr_cnt < 2; i++) @(negedge clk);
        full_hold = 4;
      end
    join

    for (int t = 0; t < 8; t++)
      run(8'($urandom), $urandom_range(1, 6), $urandom_range(1, 4), 1'b1, 1'b0);

    // reset after the second write aborts the transfer
    build_model(8'd30, 4, 2);
    pulse_start(8'd30, 4, 2);
    for (int i = 0; i < 100 && wr_cnt < 2; i++) begin
      @(negedge clk); #1;
    end
    check("abort_reached_2nd", 32'(wr_cnt), 2);
    mon_en = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    check("abort_outputs", 32'({IFMAP, write_en_IFMAP, busy, done, mem_rd_en}), 0);
    check("abort_addr", 32'(mem_addr), 0);
    rst = 1'b1;
    last_word = '0;
    word_q.delete();
    addr_q.delete();
    wr_cnt = 0;
    done_cnt = 0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 0);
    check("abort_no_write", 32'(wr_cnt), 0);
    run(8'd30, 4, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
